// File: rtl/sha3_perm_ctrl.sv
// Sequences full rate blocks from the padder into the Keccak-f[1600] round datapath.
// Optional macro SHA3_PERM_CTRL_DUAL_ROUND_EN: two rounds per round_en cycle.
module sha3_perm_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int RIDX_W     = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              blk_valid,
  input  logic              blk_last,
  output logic              blk_ack,
  output logic              absorb,
  output logic              round_en,
  output logic [RIDX_W-1:0] round_idx,
  output logic              state_clr,
  output logic              busy,
  output logic              hash_valid,
  input  logic              hash_ack
);

`ifdef SHA3_PERM_CTRL_DUAL_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [RIDX_W-1:0] TERM = RIDX_W'(NUM_ROUNDS - STEP);
  localparam logic [RIDX_W-1:0] INC  = RIDX_W'(STEP);

  typedef enum logic [1:0] {IDLE, ABSORB, ROUND, DONE} state_t;

  state_t            state;
  logic [RIDX_W-1:0] cnt;
  logic              last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_q     <= 1'b0;
      blk_ack    <= 1'b0;
      absorb     <= 1'b0;
      round_en   <= 1'b0;
      round_idx  <= '0;
      state_clr  <= 1'b0;
      busy       <= 1'b0;
      hash_valid <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to zero unless a transition below raises them.
      blk_ack   <= 1'b0;
      absorb    <= 1'b0;
      state_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (blk_valid) begin
            last_q  <= blk_last;
            blk_ack <= 1'b1;
            absorb  <= 1'b1;
            busy    <= 1'b1;
            state   <= ABSORB;
          end
        end
        ABSORB: begin
          cnt       <= '0;
          round_en  <= 1'b1;
          round_idx <= '0;
          state     <= ROUND;
        end
        ROUND: begin
          if (cnt == TERM) begin
            // cnt parks at TERM; round_idx returns to 0 with round_en.
            round_en   <= 1'b0;
            round_idx  <= '0;
            hash_valid <= last_q;
            busy       <= last_q;
            state      <= last_q ? DONE : IDLE;
          end else begin
            cnt       <= cnt + INC;
            round_idx <= cnt + INC;
          end
        end
        DONE: begin
          if (hash_ack) begin
            hash_valid <= 1'b0;
            state_clr  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_perm_ctrl.sv
// Scoreboard bench for sha3_perm_ctrl: a timing model of each block predicts output events,
// a negedge monitor pops and compares them. Honours SHA3_PERM_CTRL_DUAL_ROUND_EN.
module tb_sha3_perm_ctrl;
  localparam int NR = 24;
`ifdef SHA3_PERM_CTRL_DUAL_ROUND_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int RC = NR / STEP;
  localparam int K_ABS = 0, K_RND = 1, K_HASH = 2, K_CLR = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       blk_valid = 1'b0;
  logic       blk_last = 1'b0;
  logic       hash_ack = 1'b0;
  logic       blk_ack, absorb, round_en, state_clr, busy, hash_valid;
  logic [4:0] round_idx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int idle_from = 0;
  int s_cyc = 0;
  int ack_rel = 0;
  bit pend_last = 1'b0;
  logic hv_prev = 1'b0;

  typedef struct {int kind; int cyc; int idx;} ev_t;
  ev_t exp_q[$];

  sha3_perm_ctrl #(.NUM_ROUNDS(NR), .RIDX_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .blk_valid(blk_valid), .blk_last(blk_last),
    .blk_ack(blk_ack), .absorb(absorb), .round_en(round_en), .round_idx(round_idx),
    .state_clr(state_clr), .busy(busy), .hash_valid(hash_valid), .hash_ack(hash_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push_ev(input int kind, input int c, input int idx);
    ev_t e;
    e.kind = kind; e.cyc = c; e.idx = idx;
    exp_q.push_back(e);
  endfunction

  task automatic expect_ev(input int kind, input int idx, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: unexpected event at cycle %0d, expected none", name, cyc);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check({name, "_cycle"}, cyc, e.cyc);
      check({name, "_idx"}, idx, e.idx);
    end
  endtask

  // Monitor: one line per observed transaction, compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      hv_prev = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missed_event: kind %0d due at cycle %0d, not seen by cycle %0d",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      check("busy", busy, {31'd0, absorb | round_en | hash_valid});
      if (!round_en) check("idx_idle", round_idx, 0);
      if (absorb || blk_ack) begin
        $display("cycle %0d: absorb/blk_ack", cyc);
        expect_ev(K_ABS, 0, "absorb");
        check("blk_ack", blk_ack, 1);
        check("absorb", absorb, 1);
      end
      if (round_en) expect_ev(K_RND, round_idx, "round");
      if (hash_valid && !hv_prev) begin
        $display("cycle %0d: hash_valid rises", cyc);
        expect_ev(K_HASH, 0, "hash");
      end
      if (hv_prev && !hash_valid) check("hv_drop_with_clr", state_clr, 1);
      if (state_clr) begin
        $display("cycle %0d: state_clr", cyc);
        expect_ev(K_CLR, 0, "clr");
        check("clr_hv_low", hash_valid, 0);
      end
      hv_prev = hash_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_blk_ack"}, blk_ack, 0);
    check({tag, "_absorb"}, absorb, 0);
    check({tag, "_round_en"}, round_en, 0);
    check({tag, "_round_idx"}, round_idx, 0);
    check({tag, "_state_clr"}, state_clr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_hash_valid"}, hash_valid, 0);
  endtask

  // One block: predict its events from its own issue time, then drive it.
  task automatic issue_block(input bit last, input int abort_at, input bit hold_next,
                             input bit next_last, input bit noisy);
    int t;
    int d;
    if (!blk_valid) begin
      blk_valid = 1'b1;
      blk_last  = last;
      s_cyc     = cyc;
    end
    t = ((s_cyc > idle_from) ? s_cyc : idle_from) + 1;
    push_ev(K_ABS, t, 0);
    for (int i = 0; i < RC; i++) push_ev(K_RND, t + 1 + i, i * STEP);
    if (blk_last) push_ev(K_HASH, t + RC + 1, 0);
    last = blk_last;
    while (cyc < t) begin
      if (cyc >= ack_rel) hash_ack = 1'b0;
      step();
    end
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    while (cyc <= t + RC) begin
      if (abort_at >= 0 && cyc == t + 1 + abort_at) begin
        reset_n = 1'b0;
        exp_q.delete();
        blk_valid = 1'b0;
        hash_ack  = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (2) step();
        check_all_zero("abort_hold");
        reset_n = 1'b1;
        step();
        check_all_zero("abort_release");
        idle_from = cyc;
        return;
      end
      if (noisy) begin
        blk_valid = 1'($urandom_range(0, 1));
        blk_last  = 1'($urandom_range(0, 1));
        hash_ack  = 1'($urandom_range(0, 1));
      end else if (cyc >= ack_rel) begin
        hash_ack = 1'b0;
      end
      step();
    end
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    hash_ack  = 1'b0;
    if (!last) begin
      idle_from = t + RC + 1;
      return;
    end
    d = $urandom_range(0, 4);
    repeat (d) step();
    hash_ack  = 1'b1;
    ack_rel   = cyc + $urandom_range(1, 5);
    push_ev(K_CLR, cyc + 1, 0);
    idle_from = cyc + 1;
    if (hold_next) begin
      blk_valid = 1'b1;
      blk_last  = next_last;
      s_cyc     = cyc;
    end else begin
      while (cyc < ack_rel) step();
      hash_ack = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit l;
    bit h;
    repeat (3) step();
    check_all_zero("in_reset");
    reset_n = 1'b1;
    step();
    check_all_zero("after_reset");
    idle_from = cyc;

    issue_block(1'b1, -1, 1'b0, 1'b0, 1'b0);          // single last block
    issue_block(1'b0, -1, 1'b0, 1'b0, 1'b0);          // two-block message
    issue_block(1'b1, -1, 1'b0, 1'b0, 1'b0);
    issue_block(1'b1, -1, 1'b0, 1'b0, 1'b1);          // ignored inputs during ROUND
    issue_block(1'b1, 10 / STEP, 1'b0, 1'b0, 1'b0);   // reset abort at round_idx 10
    issue_block(1'b1, -1, 1'b0, 1'b0, 1'b0);
    issue_block(1'b1, -1, 1'b1, 1'b1, 1'b0);          // held blk_valid across DONE->IDLE
    issue_block(1'b1, -1, 1'b0, 1'b0, 1'b0);

    for (int m = 0; m < 40; m++) begin
      if (!blk_valid) begin
        repeat ($urandom_range(0, 3)) step();
        l = ($urandom_range(0, 2) == 0);
      end else begin
        l = pend_last;
      end
      h = ($urandom_range(0, 2) == 0);
      pend_last = ($urandom_range(0, 1) == 1);
      issue_block(l, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, RC - 1)) : -1,
                  h, pend_last, 1'($urandom_range(0, 1)));
    end
    if (blk_valid) issue_block(pend_last, -1, 1'b0, 1'b0, 1'b0);
    repeat (NR + 10) begin
      if (cyc >= ack_rel) hash_ack = 1'b0;
      step();
    end
    if (hash_valid) begin
      hash_ack = 1'b1;
      step();
      hash_ack = 1'b0;
    end
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
